// File: rtl/fifo4_4b_pkg.sv
// Shared sizing and reset constants for the 4-entry, 4-bit buffer that feeds the 4:1 mux.
// The widths are fixed by the downstream mux and are not meant to be overridden.
package fifo4_4b_pkg;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int CNT_W = 3;

    localparam logic [WIDTH-1:0] SLOT_RST = 4'b0000;
    localparam logic [PTR_W-1:0] SEL_RST  = 2'b00;
    localparam logic [CNT_W-1:0] CNT_FULL = 3'd4;
endpackage

// File: rtl/fifo4_4b_src_dff4_en.sv
// Purpose: 4-bit storage slot with write enable and synchronous active-low clear.
// Latency: q follows d one clock after en is sampled high.
// Backpressure: none; the slot captures whenever enabled.
module dff4_en
    import fifo4_4b_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= SLOT_RST;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fifo4_4b_src.sv
// Purpose: 4-entry circular buffer whose slots and read pointer drive a 4:1 mux directly.
// Latency: a push is visible on the slot outputs, and a pop on rd_sel, one clock later.
// Backpressure: push refused when full without a pop, pop refused when empty; either raises err next cycle.
module fifo4_4b_src
    import fifo4_4b_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] entry_a,
    output logic [WIDTH-1:0] entry_b,
    output logic [WIDTH-1:0] entry_c,
    output logic [WIDTH-1:0] entry_d,
    output logic [PTR_W-1:0] rd_sel,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             reject;
    logic [DEPTH-1:0] slot_en;
    logic [WIDTH-1:0] slot_q [DEPTH];

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

    // A pop frees the slot being written when full, so the push may proceed.
    assign push   = wr_en && (!full || rd_en);
    assign pop    = rd_en && !empty;
    assign reject = (wr_en && !push) || (rd_en && !pop);

    always_comb begin
        slot_en = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_en[i] = push && (wr_ptr == PTR_W'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        dff4_en u_slot (
            .clk (clk),
            .rst (rst),
            .en  (slot_en[g]),
            .d   (wr_data),
            .q   (slot_q[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= SEL_RST;
            rd_ptr <= SEL_RST;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            if (push && !pop) begin
                count <= count + 3'd1;
            end else if (pop && !push) begin
                count <= count - 3'd1;
            end
            err <= reject;
        end
    end

    assign entry_a = slot_q[0];
    assign entry_b = slot_q[1];
    assign entry_c = slot_q[2];
    assign entry_d = slot_q[3];
    assign rd_sel  = rd_ptr;

endmodule
